update_neighbor_table: RTL and testbench



---
 rtl/update_neighbor_table_if.sv | 26 ++
 rtl/update_neighbor_table.sv | 173 +++++++++++++++++
 tb/tb_update_neighbor_table.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/update_neighbor_table_if.sv
// Report handshake plus shared-memory bus for the neighbor-table writer.
interface update_neighbor_table_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                  rpt_valid;
  logic [WORD_WIDTH-1:0] rpt_id;
  logic [WORD_WIDTH-1:0] rpt_q;
  logic                  rpt_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  wr_en;
  logic                  done;
  logic                  dropped;

  modport master (
    output rpt_valid, rpt_id, rpt_q, data_in,
    input  rpt_ready, address, data_out, wr_en, done, dropped
  );

  modport slave (
    input  rpt_valid, rpt_id, rpt_q, data_in,
    output rpt_ready, address, data_out, wr_en, done, dropped
  );
endinterface

// File: rtl/update_neighbor_table.sv
// Neighbor-table writer: updates a matching entry in place or appends a new one.
// Optional KEEP_MIN_EN: a match only overwrites when the reported Q is smaller.
module update_neighbor_table #(
  parameter int          WORD_WIDTH    = 16,
  parameter int          MAX_NEIGHBORS = 32,
  parameter logic [10:0] COUNT_ADDR    = 11'h68A,
  parameter logic [10:0] ID_BASE       = 11'h148,
  parameter logic [10:0] QVAL_BASE     = 11'h1C8
) (
  input  logic                   clock,
  input  logic                   nrst,
  update_neighbor_table_if.slave bus
);
  localparam int AW = 11;
  localparam int CW = $clog2(MAX_NEIGHBORS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NEIGHBORS);

`ifdef KEEP_MIN_EN
  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_SCAN, S_APPEND, S_WR_Q, S_WR_CNT, S_DONE, S_RD_Q, S_CMP_Q
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_SCAN, S_APPEND, S_WR_Q, S_WR_CNT, S_DONE
  } state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [AW-1:0]         r_address, w_address_nxt;
  logic [WORD_WIDTH-1:0] r_data_out, w_data_out_nxt;
  logic [WORD_WIDTH-1:0] r_id, w_id_nxt;
  logic [WORD_WIDTH-1:0] r_q, w_q_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_dropped, w_dropped_nxt;
  logic                  r_new, w_new_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [CW-1:0]         r_idx, w_idx_nxt;
  logic [CW-1:0]         w_cnt_rd;
  logic [CW-1:0]         w_idx_inc;

  function automatic logic [AW-1:0] entry_addr(input logic [AW-1:0] base,
                                               input logic [CW-1:0] i);
    return base + AW'({i, 1'b0});
  endfunction

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_address  <= COUNT_ADDR;
      r_data_out <= '0;
      r_wr_en    <= 1'b0;
      r_dropped  <= 1'b0;
      r_new      <= 1'b0;
      r_id       <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_address  <= w_address_nxt;
      r_data_out <= w_data_out_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_dropped  <= w_dropped_nxt;
      r_new      <= w_new_nxt;
      r_id       <= w_id_nxt;
      r_q        <= w_q_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_address_nxt  = r_address;
    w_data_out_nxt = r_data_out;
    w_wr_en_nxt    = 1'b0;
    w_dropped_nxt  = r_dropped;
    w_new_nxt      = r_new;
    w_id_nxt       = r_id;
    w_q_nxt        = r_q;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_idx_inc      = r_idx + CW'(1);
    // A corrupt count word larger than the capacity is treated as a full table.
    w_cnt_rd       = (bus.data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? MAX_CNT
                                                                 : bus.data_in[CW-1:0];
    case (r_state)
      S_IDLE: begin
        if (bus.rpt_valid) begin
          w_id_nxt      = bus.rpt_id;
          w_q_nxt       = bus.rpt_q;
          w_address_nxt = COUNT_ADDR;
          w_dropped_nxt = 1'b0;
          w_state_nxt   = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        w_cnt_nxt = w_cnt_rd;
        w_idx_nxt = '0;
        if (w_cnt_rd == '0) begin
          w_state_nxt = S_APPEND;
        end else begin
          w_address_nxt = ID_BASE;
          w_state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (bus.data_in == r_id) begin
          w_new_nxt = 1'b0;
`ifdef KEEP_MIN_EN
          w_state_nxt = S_RD_Q;
`else
          w_state_nxt = S_WR_Q;
`endif
        end else if (w_idx_inc == r_cnt) begin
          w_state_nxt = S_APPEND;
        end else begin
          w_idx_nxt     = w_idx_inc;
          w_address_nxt = entry_addr(ID_BASE, w_idx_inc);
        end
      end
      S_APPEND: begin
        if (r_cnt == MAX_CNT) begin
          w_dropped_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_address_nxt  = entry_addr(ID_BASE, r_cnt);
          w_data_out_nxt = r_id;
          w_wr_en_nxt    = 1'b1;
          w_idx_nxt      = r_cnt;
          w_new_nxt      = 1'b1;
          w_state_nxt    = S_WR_Q;
        end
      end
      S_WR_Q: begin
        w_address_nxt  = entry_addr(QVAL_BASE, r_idx);
        w_data_out_nxt = r_q;
        w_wr_en_nxt    = 1'b1;
        w_state_nxt    = r_new ? S_WR_CNT : S_DONE;
      end
      S_WR_CNT: begin
        // Count goes out last so readers never see an entry before its data.
        w_address_nxt  = COUNT_ADDR;
        w_data_out_nxt = WORD_WIDTH'(r_cnt + CW'(1));
        w_wr_en_nxt    = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
`ifdef KEEP_MIN_EN
      S_RD_Q: begin
        w_address_nxt = entry_addr(QVAL_BASE, r_idx);
        w_state_nxt   = S_CMP_Q;
      end
      S_CMP_Q: begin
        w_state_nxt = (r_q < bus.data_in) ? S_WR_Q : S_DONE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rpt_ready = (r_state == S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.address   = r_address;
  assign bus.data_out  = r_data_out;
  assign bus.wr_en     = r_wr_en;
  assign bus.dropped   = r_dropped;

endmodule

// File: tb/tb_update_neighbor_table.sv
// Bench for update_neighbor_table: directed table scenarios, mid-scan reset, random reports vs a table model.
module tb_update_neighbor_table;
  localparam logic [10:0] COUNT_ADDR = 11'h68A;
  localparam logic [10:0] ID_BASE    = 11'h148;
  localparam logic [10:0] QVAL_BASE  = 11'h1C8;
  localparam int          MAXN       = 32;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  update_neighbor_table_if bus ();

  update_neighbor_table dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  logic [15:0] mem     [0:2047] = '{default: 16'h0000};
  logic [15:0] ref_mem [0:2047] = '{default: 16'h0000};
  logic [26:0] wlog[$];
  logic [26:0] exp_w[$];
  int n_pass  = 0;
  int n_total = 0;

  assign bus.data_in = mem[bus.address];

  always @(posedge clock) begin
    if (bus.wr_en === 1'b1) begin
      mem[bus.address] = bus.data_out;
      wlog.push_back({bus.address, bus.data_out});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic clear_table();
    poke(COUNT_ADDR, 16'h0000);
    for (int i = 0; i < MAXN; i++) begin
      poke(ID_BASE + 11'(2 * i), 16'h0000);
      poke(QVAL_BASE + 11'(2 * i), 16'h0000);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    if (mem[COUNT_ADDR] !== ref_mem[COUNT_ADDR]) d++;
    for (int i = 0; i < MAXN; i++) begin
      if (mem[ID_BASE + 11'(2 * i)] !== ref_mem[ID_BASE + 11'(2 * i)]) d++;
      if (mem[QVAL_BASE + 11'(2 * i)] !== ref_mem[QVAL_BASE + 11'(2 * i)]) d++;
    end
    return d;
  endfunction

  // Table semantics: find first matching ID among min(count,32) entries, else append or drop.
  task automatic model_report(input logic [15:0] id, input logic [15:0] q,
                              output bit drop, output int lat);
    int cnt;
    int hit;
    logic [10:0] a;
    exp_w.delete();
    drop = 1'b0;
    cnt  = (ref_mem[COUNT_ADDR] > 16'(MAXN)) ? MAXN : int'(ref_mem[COUNT_ADDR]);
    hit  = -1;
    for (int i = 0; i < cnt; i++)
      if (hit < 0 && ref_mem[ID_BASE + 11'(2 * i)] == id) hit = i;
    if (hit >= 0) begin
      a = QVAL_BASE + 11'(2 * hit);
`ifdef KEEP_MIN_EN
      if (q < ref_mem[a]) begin
        exp_w.push_back({a, q});
        lat = hit + 6;
      end else begin
        lat = hit + 5;
      end
`else
      exp_w.push_back({a, q});
      lat = hit + 4;
`endif
    end else if (cnt == MAXN) begin
      drop = 1'b1;
      lat  = cnt + 3;
    end else begin
      exp_w.push_back({ID_BASE + 11'(2 * cnt), id});
      exp_w.push_back({QVAL_BASE + 11'(2 * cnt), q});
      exp_w.push_back({COUNT_ADDR, 16'(cnt + 1)});
      lat = (cnt == 0) ? 5 : cnt + 5;
    end
    foreach (exp_w[k]) ref_mem[exp_w[k][26:16]] = exp_w[k][15:0];
  endtask

  task automatic run_report(input string tag, input logic [15:0] id, input logic [15:0] q);
    bit exp_drop;
    int exp_lat;
    int lat;
    model_report(id, q, exp_drop, exp_lat);
    @(negedge clock);
    check({tag, " ready_idle"}, 32'(bus.rpt_ready), 32'd1);
    wlog.delete();
    bus.rpt_valid = 1'b1;
    bus.rpt_id    = id;
    bus.rpt_q     = q;
    @(negedge clock);
    check({tag, " ready_busy"}, 32'(bus.rpt_ready), 32'd0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      bus.rpt_valid = 1'($urandom_range(0, 1));
      bus.rpt_id    = 16'($urandom);
      bus.rpt_q     = 16'($urandom);
      @(negedge clock);
      lat++;
    end
    bus.rpt_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " dropped"}, 32'(bus.dropped), 32'(exp_drop));
    @(negedge clock);
    check({tag, " done_once"}, 32'(bus.done), 32'd0);
    check({tag, " n_writes"}, 32'(wlog.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("%s write%0d", tag, i),
            (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
    check({tag, " mem"}, 32'(mem_diffs()), 32'd0);
  endtask

  initial begin
    bus.rpt_valid = 1'b0;
    bus.rpt_id    = 16'h0000;
    bus.rpt_q     = 16'h0000;
    repeat (3) @(negedge clock);
    check("rst ready",    32'(bus.rpt_ready), 32'd1);
    check("rst address",  32'(bus.address),   32'h68A);
    check("rst data_out", 32'(bus.data_out),  32'd0);
    check("rst wr_en",    32'(bus.wr_en),     32'd0);
    check("rst done",     32'(bus.done),      32'd0);
    check("rst dropped",  32'(bus.dropped),   32'd0);
    nrst = 1'b1;

    clear_table();
    run_report("empty", 16'h0005, 16'h0040);
    check("empty id",  32'(mem[11'h148]), 32'h0005);
    check("empty q",   32'(mem[11'h1C8]), 32'h0040);
    check("empty cnt", 32'(mem[11'h68A]), 32'h0001);

    clear_table();
    poke(COUNT_ADDR, 16'd3);
    poke(ID_BASE, 16'd7); poke(ID_BASE + 11'd2, 16'd9); poke(ID_BASE + 11'd4, 16'd4);
    run_report("match9", 16'd9, 16'h0100);
    check("match9 q", 32'(mem[11'h1CA]), 32'h0100);
    run_report("append2", 16'd2, 16'h0020);
    check("append2 cnt", 32'(mem[11'h68A]), 32'd4);

    clear_table();
    poke(COUNT_ADDR, 16'd32);
    for (int i = 0; i < MAXN; i++) poke(ID_BASE + 11'(2 * i), 16'(100 + i));
    run_report("full", 16'd99, 16'h0011);
    poke(COUNT_ADDR, 16'd40);
    run_report("sat_drop", 16'd99, 16'h0012);
    run_report("sat_match", 16'd105, 16'h0013);
    run_report("last_match", 16'd131, 16'h0014);

    clear_table();
    poke(COUNT_ADDR, 16'd3);
    for (int i = 0; i < 3; i++) poke(ID_BASE + 11'(2 * i), 16'd7);
    run_report("dup", 16'd7, 16'h0055);

    clear_table();
    poke(COUNT_ADDR, 16'd3);
    poke(ID_BASE, 16'd7); poke(ID_BASE + 11'd2, 16'd9); poke(ID_BASE + 11'd4, 16'd4);
    @(negedge clock);
    wlog.delete();
    bus.rpt_valid = 1'b1; bus.rpt_id = 16'd4; bus.rpt_q = 16'h0077;
    @(negedge clock);
    bus.rpt_valid = 1'b0;
    @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    check("midrst wr_en",   32'(bus.wr_en),     32'd0);
    check("midrst ready",   32'(bus.rpt_ready), 32'd1);
    check("midrst address", 32'(bus.address),   32'h68A);
    nrst = 1'b1;
    check("midrst nowrite", 32'(wlog.size()),   32'd0);
    check("midrst mem",     32'(mem_diffs()),   32'd0);
    run_report("post_rst", 16'd4, 16'h0077);

`ifdef KEEP_MIN_EN
    clear_table();
    poke(COUNT_ADDR, 16'd1);
    poke(ID_BASE, 16'd7);
    poke(QVAL_BASE, 16'h0010);
    run_report("keep_hi", 16'd7, 16'h0030);
    run_report("keep_lo", 16'd7, 16'h0008);
    check("keep_lo q", 32'(mem[11'h1C8]), 32'h0008);
`endif

    clear_table();
    for (int n = 0; n < 80; n++)
      run_report($sformatf("rnd%0d", n), 16'($urandom_range(1, 40)), 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
